// File: rtl/ofs_plat_avalon_rdwr_merge_pkg.sv
// rtl/ofs_plat_avalon_rdwr_merge_pkg.sv - shared types for the split-to-single Avalon merge
package ofs_plat_avalon_rdwr_merge_pkg;

   // Which source channel currently owns the sink request slot
   typedef enum logic {
      RD = 1'b0,
      WR = 1'b1
   } t_grant;

   // Arbiter state: free choice each cycle, or locked to an in-flight write burst
   typedef enum logic {
      IDLE_ARB = 1'b0,
      WR_BURST = 1'b1
   } t_arb_state;

   // Default field widths, shared by the top-level parameters and the request struct
   localparam int unsigned DEF_ADDR_WIDTH      = 32;
   localparam int unsigned DEF_DATA_WIDTH      = 512;
   localparam int unsigned DEF_BURST_CNT_WIDTH = 7;
   localparam int unsigned DEF_USER_WIDTH      = 4;
   localparam int unsigned DEF_RESPONSE_WIDTH  = 2;

   // Request as held in the output register, at the default widths. The top
   // level declares the same layout sized by its own parameters.
   typedef struct packed {
      logic [DEF_ADDR_WIDTH-1:0]      address;
      logic [DEF_BURST_CNT_WIDTH-1:0] burstcount;
      logic [DEF_DATA_WIDTH-1:0]      writedata;
      logic [DEF_DATA_WIDTH/8-1:0]    byteenable;
      logic [DEF_USER_WIDTH-1:0]      user;
   } t_mem_req;

endpackage

// File: rtl/ofs_plat_avalon_rdwr_merge_arb.sv
// rtl/ofs_plat_avalon_rdwr_merge_arb.sv - round-robin read/write arbiter with atomic write bursts
module ofs_plat_avalon_rdwr_merge_arb
   import ofs_plat_avalon_rdwr_merge_pkg::*;
#(
   parameter int BURST_CNT_WIDTH = DEF_BURST_CNT_WIDTH
)
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       rd_read,
   input  logic                       wr_write,
   input  logic [BURST_CNT_WIDTH-1:0] wr_burstcount,
   input  logic                       slot_free,
   output t_grant                     grant
);

   localparam logic [BURST_CNT_WIDTH-1:0] ONE = BURST_CNT_WIDTH'(1);

   t_arb_state                 state_q, state_d;
   logic [BURST_CNT_WIDTH-1:0] beats_left_q, beats_left_d;
   t_grant                     last_grant_q, last_grant_d;
   logic                       wr_acc;
   logic                       rd_acc;

   // Grant choice: locked to WR mid-burst, otherwise the lone requester or the side not served last
   always_comb begin
      grant = (last_grant_q == WR) ? RD : WR;
      if (state_q == WR_BURST) begin
         grant = WR;
      end else if (rd_read && !wr_write) begin
         grant = RD;
      end else if (wr_write && !rd_read) begin
         grant = WR;
      end
   end

   assign wr_acc = wr_write && slot_free && (grant == WR);
   assign rd_acc = rd_read  && slot_free && (grant == RD);

   // Next-state: a multi-beat write locks the arbiter until its final beat is taken
   always_comb begin
      state_d      = state_q;
      beats_left_d = beats_left_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE_ARB: begin
            if (wr_acc) begin
               last_grant_d = WR;
               // A zero burstcount is handled as a single beat
               if (wr_burstcount > ONE) begin
                  state_d      = WR_BURST;
                  beats_left_d = wr_burstcount - ONE;
               end
            end else if (rd_acc) begin
               last_grant_d = RD;
            end
         end
         WR_BURST: begin
            if (wr_acc) begin
               if (beats_left_q == ONE) begin
                  state_d      = IDLE_ARB;
                  beats_left_d = '0;
                  last_grant_d = WR;
               end else begin
                  beats_left_d = beats_left_q - ONE;
               end
            end
         end
         default: begin
            state_d = IDLE_ARB;
         end
      endcase
   end

   // Arbiter state registers; reset leaves read with priority on the first conflict
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE_ARB;
         beats_left_q <= '0;
         last_grant_q <= WR;
      end else begin
         state_q      <= state_d;
         beats_left_q <= beats_left_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Flag illegal zero-length write bursts when their first beat is taken
   always_ff @(posedge clk) begin
      if (!reset && wr_acc && (state_q == IDLE_ARB)) begin
         assert (wr_burstcount != '0) else $error("write burstcount of zero");
      end
   end

endmodule

// File: rtl/ofs_plat_avalon_mem_rdwr_if_to_mem_if.sv
// rtl/ofs_plat_avalon_mem_rdwr_if_to_mem_if.sv - merge split read/write Avalon channels onto one Avalon sink
module ofs_plat_avalon_mem_rdwr_if_to_mem_if
   import ofs_plat_avalon_rdwr_merge_pkg::*;
#(
   parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int BURST_CNT_WIDTH = DEF_BURST_CNT_WIDTH,
   parameter int USER_WIDTH      = DEF_USER_WIDTH,
   parameter int RESPONSE_WIDTH  = DEF_RESPONSE_WIDTH
)
(
   input  logic                       clk,
   input  logic                       reset,

   input  logic                       rd_read,
   input  logic [ADDR_WIDTH-1:0]      rd_address,
   input  logic [BURST_CNT_WIDTH-1:0] rd_burstcount,
   input  logic [DATA_WIDTH/8-1:0]    rd_byteenable,
   input  logic [USER_WIDTH-1:0]      rd_user,
   output logic                       rd_waitrequest,

   input  logic                       wr_write,
   input  logic [ADDR_WIDTH-1:0]      wr_address,
   input  logic [BURST_CNT_WIDTH-1:0] wr_burstcount,
   input  logic [DATA_WIDTH-1:0]      wr_writedata,
   input  logic [DATA_WIDTH/8-1:0]    wr_byteenable,
   input  logic [USER_WIDTH-1:0]      wr_user,
   output logic                       wr_waitrequest,

   output logic                       rd_readdatavalid,
   output logic [DATA_WIDTH-1:0]      rd_readdata,
   output logic [RESPONSE_WIDTH-1:0]  rd_response,
   output logic [USER_WIDTH-1:0]      rd_readresponseuser,

   output logic                       wr_writeresponsevalid,
   output logic [RESPONSE_WIDTH-1:0]  wr_response,
   output logic [USER_WIDTH-1:0]      wr_writeresponseuser,

   output logic [ADDR_WIDTH-1:0]      address,
   output logic [BURST_CNT_WIDTH-1:0] burstcount,
   output logic [DATA_WIDTH-1:0]      writedata,
   output logic [DATA_WIDTH/8-1:0]    byteenable,
   output logic [USER_WIDTH-1:0]      user,
   output logic                       read,
   output logic                       write,
   input  logic                       waitrequest,

   input  logic                       readdatavalid,
   input  logic [DATA_WIDTH-1:0]      readdata,
   input  logic [RESPONSE_WIDTH-1:0]  response,
   input  logic [USER_WIDTH-1:0]      readresponseuser,

   input  logic                       writeresponsevalid,
   input  logic [RESPONSE_WIDTH-1:0]  writeresponse,
   input  logic [USER_WIDTH-1:0]      writeresponseuser
);

   localparam logic [BURST_CNT_WIDTH-1:0] ONE = BURST_CNT_WIDTH'(1);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]      address;
      logic [BURST_CNT_WIDTH-1:0] burstcount;
      logic [DATA_WIDTH-1:0]      writedata;
      logic [DATA_WIDTH/8-1:0]    byteenable;
      logic [USER_WIDTH-1:0]      user;
   } t_req;

   t_req                       req_q, req_d;
   logic                       read_q, read_d;
   logic                       write_q, write_d;
   logic                       slot_free;
   logic                       rd_acc;
   logic                       wr_acc;
   t_grant                     grant;
   logic [BURST_CNT_WIDTH-1:0] rd_bc_fix;
   logic [BURST_CNT_WIDTH-1:0] wr_bc_fix;

   // The slot frees when empty or when the sink takes its current request;
   // held closed during reset so neither source sees acceptance.
   assign slot_free = !reset && (!(read_q || write_q) || !waitrequest);

   assign rd_acc = rd_read  && slot_free && (grant == RD);
   assign wr_acc = wr_write && slot_free && (grant == WR);

   assign rd_waitrequest = !(slot_free && (grant == RD));
   assign wr_waitrequest = !(slot_free && (grant == WR));

   // Zero-length bursts are forwarded as single beats
   assign rd_bc_fix = (rd_burstcount == '0) ? ONE : rd_burstcount;
   assign wr_bc_fix = (wr_burstcount == '0) ? ONE : wr_burstcount;

   ofs_plat_avalon_rdwr_merge_arb #(
      .BURST_CNT_WIDTH(BURST_CNT_WIDTH)
   ) u_arb (
      .clk          (clk),
      .reset        (reset),
      .rd_read      (rd_read),
      .wr_write     (wr_write),
      .wr_burstcount(wr_burstcount),
      .slot_free    (slot_free),
      .grant        (grant)
   );

   // Output register next-state: capture the granted request, otherwise hold for the sink
   always_comb begin
      read_d  = read_q;
      write_d = write_q;
      req_d   = req_q;
      if (slot_free) begin
         read_d  = rd_acc;
         write_d = wr_acc;
         if (rd_acc) begin
            req_d.address    = rd_address;
            req_d.burstcount = rd_bc_fix;
            req_d.byteenable = rd_byteenable;
            req_d.user       = rd_user;
         end else if (wr_acc) begin
            req_d.address    = wr_address;
            req_d.burstcount = wr_bc_fix;
            req_d.writedata  = wr_writedata;
            req_d.byteenable = wr_byteenable;
            req_d.user       = wr_user;
         end
      end
   end

   // One-deep request register toward the sink; reset drops any partial burst
   always_ff @(posedge clk) begin
      if (reset) begin
         read_q  <= 1'b0;
         write_q <= 1'b0;
         req_q   <= '0;
      end else begin
         read_q  <= read_d;
         write_q <= write_d;
         req_q   <= req_d;
      end
   end

   // Flag illegal zero-length read bursts as they are accepted
   always_ff @(posedge clk) begin
      if (rd_acc) begin
         assert (rd_burstcount != '0) else $error("read burstcount of zero");
      end
   end

   assign address    = req_q.address;
   assign burstcount = req_q.burstcount;
   assign writedata  = req_q.writedata;
   assign byteenable = req_q.byteenable;
   assign user       = req_q.user;
   assign read       = read_q;
   assign write      = write_q;

   assign rd_readdatavalid    = readdatavalid;
   assign rd_readdata         = readdata;
   assign rd_response         = response;
   assign rd_readresponseuser = readresponseuser;

   assign wr_writeresponsevalid = writeresponsevalid;
   assign wr_response           = writeresponse;
   assign wr_writeresponseuser  = writeresponseuser;

endmodule

// File: tb/tb_ofs_plat_avalon_mem_rdwr_if_to_mem_if.sv
// tb/tb_ofs_plat_avalon_mem_rdwr_if_to_mem_if.sv - directed scoreboard bench for the read/write merge
module tb_ofs_plat_avalon_mem_rdwr_if_to_mem_if;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int BW = 7;
   localparam int UW = 4;
   localparam int RW = 2;

   logic          clk;
   logic          reset;
   logic          rd_read;
   logic [AW-1:0] rd_address;
   logic [BW-1:0] rd_burstcount;
   logic [DW/8-1:0] rd_byteenable;
   logic [UW-1:0] rd_user;
   logic          rd_waitrequest;
   logic          wr_write;
   logic [AW-1:0] wr_address;
   logic [BW-1:0] wr_burstcount;
   logic [DW-1:0] wr_writedata;
   logic [DW/8-1:0] wr_byteenable;
   logic [UW-1:0] wr_user;
   logic          wr_waitrequest;
   logic          rd_readdatavalid;
   logic [DW-1:0] rd_readdata;
   logic [RW-1:0] rd_response;
   logic [UW-1:0] rd_readresponseuser;
   logic          wr_writeresponsevalid;
   logic [RW-1:0] wr_response;
   logic [UW-1:0] wr_writeresponseuser;
   logic [AW-1:0] address;
   logic [BW-1:0] burstcount;
   logic [DW-1:0] writedata;
   logic [DW/8-1:0] byteenable;
   logic [UW-1:0] user;
   logic          read;
   logic          write;
   logic          waitrequest;
   logic          readdatavalid;
   logic [DW-1:0] readdata;
   logic [RW-1:0] response;
   logic [UW-1:0] readresponseuser;
   logic          writeresponsevalid;
   logic [RW-1:0] writeresponse;
   logic [UW-1:0] writeresponseuser;

   ofs_plat_avalon_mem_rdwr_if_to_mem_if #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW),
      .USER_WIDTH(UW), .RESPONSE_WIDTH(RW)
   ) dut (
      .clk(clk), .reset(reset),
      .rd_read(rd_read), .rd_address(rd_address), .rd_burstcount(rd_burstcount),
      .rd_byteenable(rd_byteenable), .rd_user(rd_user), .rd_waitrequest(rd_waitrequest),
      .wr_write(wr_write), .wr_address(wr_address), .wr_burstcount(wr_burstcount),
      .wr_writedata(wr_writedata), .wr_byteenable(wr_byteenable), .wr_user(wr_user),
      .wr_waitrequest(wr_waitrequest),
      .rd_readdatavalid(rd_readdatavalid), .rd_readdata(rd_readdata),
      .rd_response(rd_response), .rd_readresponseuser(rd_readresponseuser),
      .wr_writeresponsevalid(wr_writeresponsevalid), .wr_response(wr_response),
      .wr_writeresponseuser(wr_writeresponseuser),
      .address(address), .burstcount(burstcount), .writedata(writedata),
      .byteenable(byteenable), .user(user), .read(read), .write(write),
      .waitrequest(waitrequest),
      .readdatavalid(readdatavalid), .readdata(readdata), .response(response),
      .readresponseuser(readresponseuser),
      .writeresponsevalid(writeresponsevalid), .writeresponse(writeresponse),
      .writeresponseuser(writeresponseuser)
   );

   typedef struct {
      logic          is_wr;
      logic [AW-1:0] addr;
      logic [BW-1:0] bc;
      logic [DW-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic push(input logic is_wr, input logic [AW-1:0] a, input logic [BW-1:0] bc,
                       input logic [DW-1:0] d);
      exp_t e;
      e.is_wr = is_wr;
      e.addr  = a;
      e.bc    = bc;
      e.data  = d;
      exp_q.push_back(e);
   endtask

   // Sink-side monitor: every transfer the sink takes is compared against the scoreboard
   always @(negedge clk) begin
      if (!reset) begin
         chk("rd_wr_exclusive", 64'(read && write), 64'd0);
         if ((read || write) && !waitrequest) begin
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               chk("xfer_is_write", 64'(write), 64'(mon_e.is_wr));
               chk("xfer_address", 64'(address), 64'(mon_e.addr));
               chk("xfer_burstcount", 64'(burstcount), 64'(mon_e.bc));
               if (mon_e.is_wr) chk("xfer_writedata", 64'(writedata), 64'(mon_e.data));
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      rd_read = 1'b0; rd_address = '0; rd_burstcount = '0; rd_byteenable = '1; rd_user = 4'h3;
      wr_write = 1'b0; wr_address = '0; wr_burstcount = '0; wr_writedata = '0;
      wr_byteenable = '1; wr_user = 4'h5;
      waitrequest = 1'b0;
      readdatavalid = 1'b0; readdata = '0; response = '0; readresponseuser = '0;
      writeresponsevalid = 1'b0; writeresponse = '0; writeresponseuser = '0;

      // Reset state
      repeat (3) cyc();
      smp();
      chk("rst_rd_waitrequest", 64'(rd_waitrequest), 64'd1);
      chk("rst_wr_waitrequest", 64'(wr_waitrequest), 64'd1);
      chk("rst_read", 64'(read), 64'd0);
      chk("rst_write", 64'(write), 64'd0);
      chk("rst_address", 64'(address), 64'd0);
      chk("rst_burstcount", 64'(burstcount), 64'd0);
      cyc();
      reset = 1'b0;

      // Single read, a second read taken just before reset
      rd_read = 1'b1; rd_address = 32'h40; rd_burstcount = 7'd4;
      push(1'b0, 32'h40, 7'd4, '0);
      smp();
      chk("t1_rd_accept", 64'(rd_waitrequest), 64'd0);
      cyc();
      rd_address = 32'h44;
      smp();
      chk("t1_read", 64'(read), 64'd1);
      chk("t1_address", 64'(address), 64'h40);
      chk("t1_burstcount", 64'(burstcount), 64'd4);
      cyc();
      rd_read = 1'b0;
      reset = 1'b1;
      smp();
      chk("t1_rst_rd_wait", 64'(rd_waitrequest), 64'd1);
      chk("t1_rst_wr_wait", 64'(wr_waitrequest), 64'd1);
      cyc();
      smp();
      chk("t1_post_rst_read", 64'(read), 64'd0);
      chk("t1_post_rst_write", 64'(write), 64'd0);
      cyc();
      reset = 1'b0;

      // Simultaneous single requests alternate starting with read
      rd_read = 1'b1; rd_address = 32'h100; rd_burstcount = 7'd1;
      wr_write = 1'b1; wr_address = 32'h200; wr_burstcount = 7'd1; wr_writedata = 64'h1111;
      for (int i = 0; i < 2; i++) begin
         push(1'b0, 32'h100, 7'd1, '0);
         push(1'b1, 32'h200, 7'd1, 64'h1111);
      end
      for (int i = 0; i < 4; i++) begin
         smp();
         chk($sformatf("t2_rd_wait_%0d", i), 64'(rd_waitrequest), 64'(i % 2));
         chk($sformatf("t2_wr_wait_%0d", i), 64'(wr_waitrequest), 64'((i + 1) % 2));
         cyc();
      end
      rd_read = 1'b0; wr_write = 1'b0;
      smp();
      cyc();

      // Four-beat write burst locks out a read arriving after the first beat
      wr_write = 1'b1; wr_address = 32'h300; wr_burstcount = 7'd4; wr_writedata = 64'hD0;
      for (int i = 0; i < 4; i++) push(1'b1, 32'h300, 7'd4, 64'hD0 + 64'(i));
      push(1'b0, 32'h400, 7'd1, '0);
      smp();
      chk("t3_first_beat", 64'(wr_waitrequest), 64'd0);
      cyc();
      rd_read = 1'b1; rd_address = 32'h400; rd_burstcount = 7'd1;
      for (int i = 1; i < 4; i++) begin
         wr_writedata = 64'hD0 + 64'(i);
         smp();
         chk($sformatf("t3_rd_locked_%0d", i), 64'(rd_waitrequest), 64'd1);
         chk($sformatf("t3_wr_beat_%0d", i), 64'(wr_waitrequest), 64'd0);
         cyc();
      end
      wr_write = 1'b0;
      smp();
      chk("t3_rd_after_burst", 64'(rd_waitrequest), 64'd0);
      cyc();
      rd_read = 1'b0;
      smp();
      cyc();

      // Sink backpressure for three cycles with another read pending
      rd_read = 1'b1; rd_address = 32'h500; rd_burstcount = 7'd2;
      push(1'b0, 32'h500, 7'd2, '0);
      push(1'b0, 32'h600, 7'd1, '0);
      smp();
      chk("t4_rd_accept", 64'(rd_waitrequest), 64'd0);
      cyc();
      waitrequest = 1'b1;
      rd_address = 32'h600; rd_burstcount = 7'd1;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk($sformatf("t4_read_%0d", i), 64'(read), 64'd1);
         chk($sformatf("t4_address_%0d", i), 64'(address), 64'h500);
         chk($sformatf("t4_burstcount_%0d", i), 64'(burstcount), 64'd2);
         chk($sformatf("t4_rd_wait_%0d", i), 64'(rd_waitrequest), 64'd1);
         chk($sformatf("t4_wr_wait_%0d", i), 64'(wr_waitrequest), 64'd1);
         cyc();
      end
      chk("t4_no_xfer_during_stall", 64'(exp_q.size()), 64'd2);
      waitrequest = 1'b0;
      smp();
      chk("t4_rd_after_stall", 64'(rd_waitrequest), 64'd0);
      cyc();
      rd_read = 1'b0;
      smp();
      cyc();
      chk("t4_sb_drained", 64'(exp_q.size()), 64'd0);

      // Reset in the middle of a four-beat write burst
      wr_write = 1'b1; wr_address = 32'h800; wr_burstcount = 7'd4; wr_writedata = 64'hE0;
      push(1'b1, 32'h800, 7'd4, 64'hE0);
      smp();
      cyc();
      wr_writedata = 64'hE1;
      smp();
      cyc();
      wr_write = 1'b0;
      reset = 1'b1;
      smp();
      chk("t5_rst_rd_wait", 64'(rd_waitrequest), 64'd1);
      chk("t5_rst_wr_wait", 64'(wr_waitrequest), 64'd1);
      cyc();
      reset = 1'b0;
      rd_read = 1'b1; rd_address = 32'h900; rd_burstcount = 7'd1;
      push(1'b0, 32'h900, 7'd1, '0);
      smp();
      chk("t5_write_dropped", 64'(write), 64'd0);
      chk("t5_read_idle", 64'(read), 64'd0);
      chk("t5_rd_accept", 64'(rd_waitrequest), 64'd0);
      cyc();
      rd_read = 1'b0;
      smp();
      cyc();

      // Read and write responses in the same cycle
      readdatavalid = 1'b1; readdata = 64'hA5A5; response = 2'b10; readresponseuser = 4'h9;
      writeresponsevalid = 1'b1; writeresponse = 2'b01; writeresponseuser = 4'h6;
      #1;
      chk("t6_rd_valid", 64'(rd_readdatavalid), 64'd1);
      chk("t6_rd_data", 64'(rd_readdata), 64'hA5A5);
      chk("t6_rd_response", 64'(rd_response), 64'd2);
      chk("t6_rd_user", 64'(rd_readresponseuser), 64'h9);
      chk("t6_wr_valid", 64'(wr_writeresponsevalid), 64'd1);
      chk("t6_wr_response", 64'(wr_response), 64'd1);
      chk("t6_wr_user", 64'(wr_writeresponseuser), 64'h6);
      cyc();
      readdatavalid = 1'b0; writeresponsevalid = 1'b0;
      #1;
      chk("t6_rd_valid_low", 64'(rd_readdatavalid), 64'd0);
      chk("t6_wr_valid_low", 64'(wr_writeresponsevalid), 64'd0);

      repeat (3) cyc();
      chk("final_sb_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
